// File: rtl/next_pc_if.sv
// Fetch-side bundle for next_pc_unit: redirect/stall requests in, fetch PC and status out.
// The master modport is the core/pipeline side; the slave modport is the PC unit.
interface next_pc_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             fetch_ready;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic             jump_valid;
  logic [XLEN-1:0]  jump_target;
  logic             trap_req;
  logic             halt_req;
  logic             resume;
  logic [XLEN-1:0]  pc;
  logic             pc_valid;
  logic [XLEN-1:0]  pc_plus4;
  logic             flush;
  logic [CNT_W-1:0] redirect_cnt;
  logic             misalign_err;

  modport master (
    output fetch_ready, branch_taken, branch_target, jump_valid, jump_target,
           trap_req, halt_req, resume,
    input  pc, pc_valid, pc_plus4, flush, redirect_cnt, misalign_err
  );

  modport slave (
    input  fetch_ready, branch_taken, branch_target, jump_valid, jump_target,
           trap_req, halt_req, resume,
    output pc, pc_valid, pc_plus4, flush, redirect_cnt, misalign_err
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC generator with BOOT/RUN/HALT control, prioritised redirects and a saturating redirect counter.
// Optional misaligned-target trapping is enabled by defining NEXT_PC_MISALIGN_CHK_EN.
module next_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              CNT_W     = 16
) (
  input  logic     clk,
  input  logic     rst,
  next_pc_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  pc_plus4_s;
  logic [XLEN-1:0]  tgt_s;
  logic [XLEN-1:0]  tgt_pc_s;
  logic             bad_tgt_s;
  logic             redirect_s;

  assign pc_plus4_s = pc_q + XLEN'(4);

  // Jump outranks branch; jump targets lose bit 0 before any alignment decision.
  always_comb begin
    tgt_s = bus.branch_target;
    if (bus.jump_valid) begin
      tgt_s = bus.jump_target & ~XLEN'(1);
    end else begin
      tgt_s = bus.branch_target;
    end
  end

`ifdef NEXT_PC_MISALIGN_CHK_EN
  assign bad_tgt_s = (tgt_s[1:0] != 2'b00);
  assign tgt_pc_s  = bad_tgt_s ? TRAP_VEC : tgt_s;
`else
  assign bad_tgt_s = 1'b0;
  assign tgt_pc_s  = {tgt_s[XLEN-1:2], 2'b00};
`endif

  // Next-state, next-PC and redirect decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_s = 1'b0;
    mis_d      = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.trap_req) begin
          pc_d       = TRAP_VEC;
          redirect_s = 1'b1;
        end else if (bus.jump_valid || bus.branch_taken) begin
          pc_d       = tgt_pc_s;
          redirect_s = 1'b1;
          mis_d      = bad_tgt_s;
        end else if (bus.fetch_ready) begin
          pc_d = pc_plus4_s;
        end else begin
          pc_d = pc_q;
        end
        if (bus.halt_req) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (bus.trap_req) begin
          pc_d       = TRAP_VEC;
          redirect_s = 1'b1;
          state_d    = RUN;
        end else if (bus.resume) begin
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    flush_d = redirect_s;
    if (redirect_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers; reset wins over every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = (state_q == RUN);
  assign bus.pc_plus4     = pc_plus4_s;
  assign bus.flush        = flush_q;
  assign bus.redirect_cnt = cnt_q;
  assign bus.misalign_err = mis_q;

endmodule
